dbus_uncached_responder: RTL and testbench
==========================================

Name: dbus_uncached_responder

Overview:
Slave-side responder for the uncached half of the CPU data bus. It accepts one 64-bit uncached read or write, with an 8-byte-aligned address and 8-bit byteenable, while holding the CPU with uncached_stall. It splits the access into at most two 32-bit beats on a simple valid/ready memory channel toward the uncached bus bridge, then returns read data. The cached path (read, write, stall, rddata) and the cache-invalidate signals are handled by the D$ and are not touched here.

Parameters:
SKIP_ZERO_STROBE, 1, when 1, beats whose 4-bit strobe is zero are not issued; when 0, both beats are always issued.
RESET_RDATA, 64'h0, value driven on uncached_rddata after reset.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
uncached_read  input  1  CPU uncached read request, held until stall drops
uncached_write  input  1  CPU uncached write request, held until stall drops
address  input  32  byte address, 8-byte aligned; [2:0] ignored
byteenable  input  8  byte lanes; [3:0] low word, [7:4] high word
wrdata  input  64  write data
uncached_stall  output  1  hold CPU
uncached_rddata  output  64  read result, valid in the DONE cycle and held until next completion
req_valid  output  1  beat request valid
req_ready  input  1  bridge accepts beat
req_we  output  1  1 = write beat
req_addr  output  32  word address of beat
req_wstrb  output  4  beat byte strobe
req_wdata  output  32  beat write data
resp_valid  input  1  beat response (read data or write ack), in order
resp_rdata  input  32  read data for read beats

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - req_valid=0; req_we, req_addr, req_wstrb, req_wdata all 0.
  - uncached_rddata=RESET_RDATA.
  - uncached_stall=0 while in IDLE with no request.
  - Reset mid-operation abandons the transfer. A resp_valid arriving with no beat outstanding is ignored.
- States: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
- IDLE, on uncached_read or uncached_write:
  - uncached_stall=1 combinationally in the same cycle.
  - Latch address[31:3], byteenable, wrdata, and we=uncached_write. Write has priority if both are asserted.
  - Next state: REQ0 if the low strobe is active, else REQ1 if the high strobe is active, else DONE.
  - "Active" means strobe nonzero, or SKIP_ZERO_STROBE=0.
- REQ0:
  - req_valid=1, req_addr={addr[31:3],3'b000}, req_wstrb=be[3:0], req_wdata=wdata[31:0], req_we=we.
  - Go to RSP0 on req_ready.
  - Request fields stay stable while req_valid=1 and req_ready=0.
- RSP0:
  - req_valid=0.
  - On resp_valid: if read, latch resp_rdata into the low word.
  - Then go to REQ1 if the high strobe is active, else DONE.
- REQ1 / RSP1: same as REQ0 / RSP0 with req_addr={addr[31:3],3'b100}, be[7:4], wdata[63:32], and the high word. RSP1 goes to DONE.
- req_ready and resp_valid may both be asserted in the same cycle as a request; a response is only taken in an RSP state (at least 1 cycle after acceptance).
- DONE:
  - uncached_stall=0 for exactly one cycle.
  - For reads, uncached_rddata is updated on entry: fetched words carry data, unfetched words are 0.
  - Writes leave uncached_rddata unchanged.
  - The request is consumed at this edge; next state is IDLE.
- A new request seen in IDLE the following cycle is a new access (back-to-back allowed).
- uncached_stall=1 in REQ0, RSP0, REQ1 and RSP1.
- Latency: minimum 4 cycles for a two-beat access with req_ready=1 and a 1-cycle response; DONE follows directly after the IDLE cycle when both strobes are zero.
- At most one beat is outstanding. No address arithmetic overflow is possible because the beat offset is fixed at +4 within an aligned 8-byte block.

Test Plan:
- Read addr=0x1FC0_0008, be=0xFF; bridge responds 0x11111111 then 0x22222222 -> two beats at 0x1FC00008 and 0x1FC0000C, rddata=0x22222222_11111111, stall low exactly one cycle.
- Write addr=0xBFD0_03F8, be=0xF0, wrdata=0xAABBCCDD_00000000 (SKIP_ZERO_STROBE=1) -> single beat: addr 0xBFD003FC, wstrb=0xF, wdata=0xAABBCCDD; rddata unchanged.
- Read be=0x0F with req_ready low for 5 cycles -> req_valid held with stable fields; beat accepted on cycle 6; rddata upper word = 0.
- Read and write both asserted, be=0x00 -> write path taken, no beats issued, DONE reached one cycle after IDLE, stall high only in the IDLE cycle.
- rst_n pulled low during RSP1, then a stray resp_valid arrives -> IDLE, req_valid=0, stall=0, rddata=RESET_RDATA; the stray response is ignored.
- Back-to-back: a second read is presented in the cycle after DONE -> a new access starts with no lost or duplicated beats; SKIP_ZERO_STROBE=0 with be=0x0F issues both beats.

Source files
------------

// File: rtl/dbus_uncached_responder_if.sv
// Signal bundle between the CPU uncached data port, the responder and the
// uncached bus bridge beat channel.
interface dbus_uncached_responder_if;
   logic        uncached_read;
   logic        uncached_write;
   logic [31:0] address;
   logic [7:0]  byteenable;
   logic [63:0] wrdata;
   logic        uncached_stall;
   logic [63:0] uncached_rddata;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;

   modport slave (
      input  uncached_read, uncached_write, address, byteenable, wrdata,
      input  req_ready, resp_valid, resp_rdata,
      output uncached_stall, uncached_rddata,
      output req_valid, req_we, req_addr, req_wstrb, req_wdata
   );

   modport master (
      output uncached_read, uncached_write, address, byteenable, wrdata,
      output req_ready, resp_valid, resp_rdata,
      input  uncached_stall, uncached_rddata,
      input  req_valid, req_we, req_addr, req_wstrb, req_wdata
   );
endinterface

// File: rtl/dbus_uncached_responder.sv
// Uncached data-bus responder: turns one 64-bit CPU access into at most two
// 32-bit beats on a valid/ready channel and assembles the read result.
module dbus_uncached_responder #(
   parameter bit          SKIP_ZERO_STROBE = 1'b1,
   parameter logic [63:0] RESET_RDATA      = 64'h0
) (
   input logic                      clk,
   input logic                      rst_n,
   dbus_uncached_responder_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ0 = 3'd1,
      RSP0 = 3'd2,
      REQ1 = 3'd3,
      RSP1 = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t      state_r, state_s;
   logic [28:0] addr_r, addr_s;
   logic [7:0]  be_r, be_s;
   logic [63:0] wdata_r, wdata_s;
   logic        we_r, we_s;
   logic [31:0] lo_r, lo_s;
   logic [31:0] hi_r, hi_s;
   logic [63:0] rddata_r, rddata_s;
   logic        req_valid_r, req_valid_s;
   logic        req_we_r, req_we_s;
   logic [31:0] req_addr_r, req_addr_s;
   logic [3:0]  req_wstrb_r, req_wstrb_s;
   logic [31:0] req_wdata_r, req_wdata_s;
   logic        stall_s;
   logic        start_s;
   logic        unused_addr_s;

   // A half is issued when it has a lane enabled, or always when skipping is off.
   function automatic logic strobe_active(input logic [3:0] strb);
      return (strb != 4'h0) || (SKIP_ZERO_STROBE == 1'b0);
   endfunction

   // Next-state decode, stall and per-beat read-data capture.
   always_comb begin
      state_s = state_r;
      stall_s = 1'b0;
      start_s = 1'b0;
      lo_s    = lo_r;
      hi_s    = hi_r;
      case (state_r)
         IDLE: begin
            if (bus.uncached_read || bus.uncached_write) begin
               stall_s = 1'b1;
               start_s = 1'b1;
               lo_s    = 32'h0;
               hi_s    = 32'h0;
               if (strobe_active(bus.byteenable[3:0])) begin
                  state_s = REQ0;
               end else if (strobe_active(bus.byteenable[7:4])) begin
                  state_s = REQ1;
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         REQ0: begin
            stall_s = 1'b1;
            if (bus.req_ready) begin
               state_s = RSP0;
            end else begin
               state_s = REQ0;
            end
         end
         RSP0: begin
            stall_s = 1'b1;
            if (bus.resp_valid) begin
               if (!we_r) begin
                  lo_s = bus.resp_rdata;
               end else begin
                  lo_s = lo_r;
               end
               if (strobe_active(be_r[7:4])) begin
                  state_s = REQ1;
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = RSP0;
            end
         end
         REQ1: begin
            stall_s = 1'b1;
            if (bus.req_ready) begin
               state_s = RSP1;
            end else begin
               state_s = REQ1;
            end
         end
         RSP1: begin
            stall_s = 1'b1;
            if (bus.resp_valid) begin
               if (!we_r) begin
                  hi_s = bus.resp_rdata;
               end else begin
                  hi_s = hi_r;
               end
               state_s = DONE;
            end else begin
               state_s = RSP1;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Access operands: taken straight from the CPU in the accept cycle, held afterwards.
   always_comb begin
      if (start_s) begin
         addr_s  = bus.address[31:3];
         be_s    = bus.byteenable;
         wdata_s = bus.wrdata;
         we_s    = bus.uncached_write;
      end else begin
         addr_s  = addr_r;
         be_s    = be_r;
         wdata_s = wdata_r;
         we_s    = we_r;
      end
   end

   // Beat fields load once on entry to a request state so they stay put while stalled.
   always_comb begin
      req_valid_s = (state_s == REQ0) || (state_s == REQ1);
      req_we_s    = req_we_r;
      req_addr_s  = req_addr_r;
      req_wstrb_s = req_wstrb_r;
      req_wdata_s = req_wdata_r;
      rddata_s    = rddata_r;
      if ((state_s == REQ0) && (state_r != REQ0)) begin
         req_we_s    = we_s;
         req_addr_s  = {addr_s, 3'b000};
         req_wstrb_s = be_s[3:0];
         req_wdata_s = wdata_s[31:0];
      end else if ((state_s == REQ1) && (state_r != REQ1)) begin
         req_we_s    = we_s;
         req_addr_s  = {addr_s, 3'b100};
         req_wstrb_s = be_s[7:4];
         req_wdata_s = wdata_s[63:32];
      end else begin
         req_we_s    = req_we_r;
         req_addr_s  = req_addr_r;
         req_wstrb_s = req_wstrb_r;
         req_wdata_s = req_wdata_r;
      end
      // Unfetched halves were cleared at accept time, so they read back as zero.
      if ((state_s == DONE) && !we_s) begin
         rddata_s = {hi_s, lo_s};
      end else begin
         rddata_s = rddata_r;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         addr_r      <= 29'h0;
         be_r        <= 8'h0;
         wdata_r     <= 64'h0;
         we_r        <= 1'b0;
         lo_r        <= 32'h0;
         hi_r        <= 32'h0;
         rddata_r    <= RESET_RDATA;
         req_valid_r <= 1'b0;
         req_we_r    <= 1'b0;
         req_addr_r  <= 32'h0;
         req_wstrb_r <= 4'h0;
         req_wdata_r <= 32'h0;
      end else begin
         state_r     <= state_s;
         addr_r      <= addr_s;
         be_r        <= be_s;
         wdata_r     <= wdata_s;
         we_r        <= we_s;
         lo_r        <= lo_s;
         hi_r        <= hi_s;
         rddata_r    <= rddata_s;
         req_valid_r <= req_valid_s;
         req_we_r    <= req_we_s;
         req_addr_r  <= req_addr_s;
         req_wstrb_r <= req_wstrb_s;
         req_wdata_r <= req_wdata_s;
      end
   end

   assign unused_addr_s       = ^bus.address[2:0];
   assign bus.uncached_stall  = stall_s;
   assign bus.uncached_rddata = rddata_r;
   assign bus.req_valid       = req_valid_r;
   assign bus.req_we          = req_we_r;
   assign bus.req_addr        = req_addr_r;
   assign bus.req_wstrb       = req_wstrb_r;
   assign bus.req_wdata       = req_wdata_r;

endmodule

// File: tb/tb_dbus_uncached_responder.sv
// Scoreboard bench: one responder with zero-strobe skipping, one without; a
// bridge model answers beats and a monitor checks beats and completions.
module tb_dbus_uncached_responder;

   localparam logic [63:0] RST_RD = 64'hCAFE_0000_0000_F00D;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dbus_uncached_responder_if bus();
   dbus_uncached_responder_if bus_ns();

   dbus_uncached_responder #(.SKIP_ZERO_STROBE(1'b1), .RESET_RDATA(RST_RD)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   dbus_uncached_responder #(.SKIP_ZERO_STROBE(1'b0), .RESET_RDATA(RST_RD)) dut_ns (
      .clk(clk), .rst_n(rst_n), .bus(bus_ns));

   beat_t       xb0[$], xb1[$];
   logic [63:0] xd0[$], xd1[$];
   logic [31:0] rdq0[$], rdq1[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          beats0 = 0;
   int          hold_cfg = 0;
   int          resp_delay = 0;
   int          rc0 = -1, rc1 = -1, hc0 = 0;
   logic [31:0] rd0 = 32'h0, rd1 = 32'h0;
   logic        ps0 = 1'b0, ps1 = 1'b0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   // bridge model: programmable ready hold-off and response delay on lane 0
   always @(negedge clk) begin
      bus.resp_valid = 1'b0;
      bus.resp_rdata = 32'h0;
      if (rc0 == 0) begin
         bus.resp_valid = 1'b1;
         bus.resp_rdata = rd0;
         rc0 = -1;
      end else if (rc0 > 0) begin
         rc0--;
      end
      if (bus.req_valid !== 1'b1) begin
         bus.req_ready = 1'b1;
         hc0 = hold_cfg;
      end else if (hc0 > 0) begin
         bus.req_ready = 1'b0;
         hc0--;
      end else begin
         bus.req_ready = 1'b1;
      end
      if (rst_n && bus.req_valid === 1'b1 && bus.req_ready) begin
         rc0 = resp_delay;
         rd0 = (bus.req_we || rdq0.size() == 0) ? 32'h0 : rdq0.pop_front();
      end
      bus_ns.resp_valid = 1'b0;
      bus_ns.resp_rdata = 32'h0;
      if (rc1 == 0) begin
         bus_ns.resp_valid = 1'b1;
         bus_ns.resp_rdata = rd1;
         rc1 = -1;
      end
      bus_ns.req_ready = 1'b1;
      if (rst_n && bus_ns.req_valid === 1'b1) begin
         rc1 = 0;
         rd1 = (bus_ns.req_we || rdq1.size() == 0) ? 32'h0 : rdq1.pop_front();
      end
   end

   // monitor: every presented beat against the queue head, rddata on each DONE
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         ps0 = 1'b0;
         ps1 = 1'b0;
      end else begin
         if (bus.req_valid === 1'b1) begin
            if (xb0.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL beat0_unexpected: got addr %h, required no beat", bus.req_addr);
            end else begin
               chk("beat0_addr", 64'(bus.req_addr), 64'(xb0[0].addr));
               chk("beat0_ctl", {27'h0, bus.req_we, bus.req_wstrb, bus.req_wdata},
                   {27'h0, xb0[0].we, xb0[0].wstrb, xb0[0].wdata});
               if (bus.req_ready) begin
                  void'(xb0.pop_front());
                  beats0++;
               end
            end
         end
         if (ps0 && !bus.uncached_stall) begin
            if (xd0.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL done0_unexpected: got rddata %h, required no completion", bus.uncached_rddata);
            end else begin
               chk("rddata0", bus.uncached_rddata, xd0.pop_front());
            end
         end
         ps0 = bus.uncached_stall;
         if (bus_ns.req_valid === 1'b1) begin
            if (xb1.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL beat1_unexpected: got addr %h, required no beat", bus_ns.req_addr);
            end else begin
               chk("beat1_addr", 64'(bus_ns.req_addr), 64'(xb1[0].addr));
               chk("beat1_ctl", {27'h0, bus_ns.req_we, bus_ns.req_wstrb, bus_ns.req_wdata},
                   {27'h0, xb1[0].we, xb1[0].wstrb, xb1[0].wdata});
               if (bus_ns.req_ready) void'(xb1.pop_front());
            end
         end
         if (ps1 && !bus_ns.uncached_stall) begin
            if (xd1.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL done1_unexpected: got rddata %h, required no completion", bus_ns.uncached_rddata);
            end else begin
               chk("rddata1", bus_ns.uncached_rddata, xd1.pop_front());
            end
         end
         ps1 = bus_ns.uncached_stall;
      end
   end

   task automatic drive(input int lane, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [7:0] be, input logic [63:0] wd);
      if (lane == 0) begin
         bus.uncached_read = rd; bus.uncached_write = wr; bus.address = a;
         bus.byteenable = be; bus.wrdata = wd;
      end else begin
         bus_ns.uncached_read = rd; bus_ns.uncached_write = wr; bus_ns.address = a;
         bus_ns.byteenable = be; bus_ns.wrdata = wd;
      end
   endtask

   // one CPU access: stall must rise in the IDLE cycle; count cycles to DONE
   task automatic do_access(input int lane, input logic rd, input logic wr, input logic [31:0] a,
                            input logic [7:0] be, input logic [63:0] wd, input int exp_cyc,
                            input string nm);
      int   cyc;
      logic st;
      @(negedge clk);
      drive(lane, rd, wr, a, be, wd);
      #1;
      st = (lane == 0) ? bus.uncached_stall : bus_ns.uncached_stall;
      chk({nm, "_stall_idle"}, 64'(st), 64'd1);
      cyc = 0;
      while (1) begin
         @(negedge clk);
         #3;
         cyc++;
         st = (lane == 0) ? bus.uncached_stall : bus_ns.uncached_stall;
         if (!st) break;
         if (cyc > 200) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got no completion in %0d cycles, required %0d", nm, cyc, exp_cyc);
            break;
         end
      end
      drive(lane, 1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
      chk({nm, "_latency"}, 64'(cyc), 64'(exp_cyc));
   endtask

   initial begin
      int base;
      int cyc;
      drive(0, 1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
      repeat (3) @(negedge clk);
      #3;
      chk("rst_stall", 64'(bus.uncached_stall), 64'd0);
      chk("rst_valid", 64'(bus.req_valid), 64'd0);
      chk("rst_fields", {27'h0, bus.req_we, bus.req_wstrb, bus.req_wdata}, 64'h0);
      chk("rst_addr", 64'(bus.req_addr), 64'h0);
      chk("rst_rddata", bus.uncached_rddata, RST_RD);
      chk("rst_rddata_ns", bus_ns.uncached_rddata, RST_RD);
      rst_n = 1'b1;

      // two-beat read
      rdq0.push_back(32'h1111_1111); rdq0.push_back(32'h2222_2222);
      xb0.push_back(beat_t'{1'b0, 32'h1FC0_0008, 4'hF, 32'h0});
      xb0.push_back(beat_t'{1'b0, 32'h1FC0_000C, 4'hF, 32'h0});
      xd0.push_back(64'h2222_2222_1111_1111);
      do_access(0, 1'b1, 1'b0, 32'h1FC0_0008, 8'hFF, 64'h0, 5, "t1");

      // high-half-only write: single beat, rddata untouched
      xb0.push_back(beat_t'{1'b1, 32'hBFD0_03FC, 4'hF, 32'hAABB_CCDD});
      xd0.push_back(64'h2222_2222_1111_1111);
      do_access(0, 1'b0, 1'b1, 32'hBFD0_03F8, 8'hF0, 64'hAABB_CCDD_0000_0000, 3, "t2");

      // low-half read with ready held off for 5 cycles; address bits [2:0] ignored
      hold_cfg = 5;
      rdq0.push_back(32'h3333_4444);
      xb0.push_back(beat_t'{1'b0, 32'h0000_1230, 4'hF, 32'h89AB_CDEF});
      xd0.push_back(64'h0000_0000_3333_4444);
      do_access(0, 1'b1, 1'b0, 32'h0000_1234, 8'h0F, 64'h0123_4567_89AB_CDEF, 8, "t3");
      hold_cfg = 0;

      // read and write together with no lanes: write wins, no beats
      xd0.push_back(64'h0000_0000_3333_4444);
      do_access(0, 1'b1, 1'b1, 32'h0000_0040, 8'h00, 64'h0, 1, "t4");

      // reset in RSP1 while the bridge answer is still in flight
      resp_delay = 4;
      rdq0.push_back(32'h7777_0000); rdq0.push_back(32'h7777_1111);
      xb0.push_back(beat_t'{1'b0, 32'h8000_0010, 4'hF, 32'h0});
      xb0.push_back(beat_t'{1'b0, 32'h8000_0014, 4'hF, 32'h0});
      base = beats0;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h8000_0010, 8'hFF, 64'h0);
      cyc = 0;
      while (beats0 < base + 2 && cyc < 200) begin
         @(negedge clk);
         #3;
         cyc++;
      end
      chk("t5_beats", 64'(beats0 - base), 64'd2);
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      chk("t5_valid", 64'(bus.req_valid), 64'd0);
      chk("t5_stall", 64'(bus.uncached_stall), 64'd0);
      chk("t5_rddata", bus.uncached_rddata, RST_RD);
      chk("t5_addr", 64'(bus.req_addr), 64'h0);
      resp_delay = 0;

      // back-to-back reads, second presented the cycle after DONE
      base = beats0;
      rdq0.push_back(32'hA5A5_A5A5);
      xb0.push_back(beat_t'{1'b0, 32'h0000_0010, 4'hF, 32'h0});
      xd0.push_back(64'h0000_0000_A5A5_A5A5);
      rdq0.push_back(32'h5A5A_5A5A);
      xb0.push_back(beat_t'{1'b0, 32'h0000_001C, 4'hF, 32'h0});
      xd0.push_back(64'h5A5A_5A5A_0000_0000);
      do_access(0, 1'b1, 1'b0, 32'h0000_0010, 8'h0F, 64'h0, 3, "t6a");
      do_access(0, 1'b1, 1'b0, 32'h0000_0018, 8'hF0, 64'h0, 3, "t6b");
      chk("t6_beats", 64'(beats0 - base), 64'd2);

      // no skipping: low-half read still issues the empty high beat
      rdq1.push_back(32'h1357_9BDF); rdq1.push_back(32'h2468_ACE0);
      xb1.push_back(beat_t'{1'b0, 32'h2000_0100, 4'hF, 32'hBEEF_0001});
      xb1.push_back(beat_t'{1'b0, 32'h2000_0104, 4'h0, 32'hFEED_0000});
      xd1.push_back(64'h2468_ACE0_1357_9BDF);
      do_access(1, 1'b1, 1'b0, 32'h2000_0100, 8'h0F, 64'hFEED_0000_BEEF_0001, 5, "t7");

      repeat (3) @(negedge clk);
      chk("left_beats0", 64'(xb0.size()), 64'd0);
      chk("left_done0", 64'(xd0.size()), 64'd0);
      chk("left_beats1", 64'(xb1.size()), 64'd0);
      chk("left_done1", 64'(xd1.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by 200000, required completion");
      $fatal(1);
   end

endmodule
